// File: rtl/bfm_apb_slave_mem_if.sv
// APB3 bus bundle between a requester and the bfm_apb_slave_mem completer.
// The requester drives select/address/control/write data; the completer answers.
interface bfm_apb_slave_mem_if;
  logic        PSEL;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PADDR, PWRITE, PENABLE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PADDR, PWRITE, PENABLE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/bfm_apb_slave_mem.sv
// APB3 completer with a word-addressed register file, programmable wait states,
// error responses, and transfer/error/protocol-violation counters.
module bfm_apb_slave_mem #(
  parameter int          DEPTH   = 16,
  parameter logic [15:0] RO_MASK = 16'h0000,
  parameter int          TPD     = 1
) (
  input  logic                PCLK,
  input  logic                PRESETN,
  bfm_apb_slave_mem_if.slave  bus,
  input  logic [3:0]          WAIT_CFG,
  output logic [15:0]         XFER_CNT,
  output logic [7:0]          ERR_CNT,
  output logic                PROTO_ERR
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, ACCESS} state_t;

  // Outputs settle with zero delay in this model; TPD is kept for drop-in compatibility.
  localparam int unused_tpd = TPD;
  logic unused_paddr;
  assign unused_paddr = ^bus.PADDR[31:10];

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [15:0] xfer_cnt_q, xfer_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        proto_err_q, proto_err_d;
  logic [9:0]  addr_q, addr_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic          ready;
  logic          err;
  logic          misaligned;
  logic          out_of_range;
  logic          ro_hit;
  logic [IW-1:0] idx;

  // Decode works purely from the address/control latched in the setup phase.
  assign idx          = addr_q[2 +: IW];
  assign misaligned   = (addr_q[1:0] != 2'b00);
  assign out_of_range = ({1'b0, addr_q[9:2]} >= 9'(DEPTH));
  assign ro_hit       = write_q && (addr_q[9:6] == 4'd0) && RO_MASK[addr_q[5:2]];
  assign err          = misaligned || out_of_range || ro_hit;
  assign ready        = (state_q == ACCESS) && (wcnt_q == 4'd0);

  assign bus.PREADY  = ready;
  assign bus.PSLVERR = ready && err;
  assign bus.PRDATA  = (ready && !write_q && !err) ? mem_q[idx] : 32'h0;

  assign XFER_CNT  = xfer_cnt_q;
  assign ERR_CNT   = err_cnt_q;
  assign PROTO_ERR = proto_err_q;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    xfer_cnt_d  = xfer_cnt_q;
    err_cnt_d   = err_cnt_q;
    proto_err_d = proto_err_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    mem_d       = mem_q;
    case (state_q)
      IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          state_d = ACCESS;
          addr_d  = bus.PADDR[9:0];
          write_d = bus.PWRITE;
          wdata_d = bus.PWDATA;
          wcnt_d  = WAIT_CFG;
        end else if (bus.PSEL && bus.PENABLE) begin
          proto_err_d = 1'b1;
        end
      end
      ACCESS: begin
        // A requester that lets go before PREADY abandons the transfer entirely.
        if (!bus.PSEL || !bus.PENABLE) begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end else if (ready) begin
          if (write_q && !err) begin
            mem_d[idx] = wdata_q;
          end
          xfer_cnt_d = xfer_cnt_q + 16'd1;
          if (err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q     <= IDLE;
      wcnt_q      <= 4'd0;
      xfer_cnt_q  <= 16'd0;
      err_cnt_q   <= 8'd0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0;
      end
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      xfer_cnt_q  <= xfer_cnt_d;
      err_cnt_q   <= err_cnt_d;
      proto_err_q <= proto_err_d;
      mem_q       <= mem_d;
    end
  end

  // Latched request fields are only consumed while in ACCESS, so they need no reset.
  always_ff @(posedge PCLK) begin
    addr_q  <= addr_d;
    write_q <= write_d;
    wdata_q <= wdata_d;
  end

endmodule

// File: tb/tb_bfm_apb_slave_mem.sv
// Directed bench for bfm_apb_slave_mem: vector table of single transfers plus
// hand-built sequences for aborts, protocol errors, reset mid-transfer, saturation.
module tb_bfm_apb_slave_mem;

  logic        PCLK = 1'b0;
  logic        PRESETN;
  logic [3:0]  WAIT_CFG;
  logic [15:0] XFER_CNT;
  logic [7:0]  ERR_CNT;
  logic        PROTO_ERR;

  bfm_apb_slave_mem_if bus();

  bfm_apb_slave_mem #(
    .DEPTH   (16),
    .RO_MASK (16'h0001),
    .TPD     (1)
  ) dut (
    .PCLK      (PCLK),
    .PRESETN   (PRESETN),
    .bus       (bus),
    .WAIT_CFG  (WAIT_CFG),
    .XFER_CNT  (XFER_CNT),
    .ERR_CNT   (ERR_CNT),
    .PROTO_ERR (PROTO_ERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wcfg;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cycles;
  } vec_t;

  vec_t vecs [11];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic bus_idle();
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 32'h0;
    bus.PWDATA  = 32'h0;
  endtask

  // Setup then access phase; request fields and WAIT_CFG are scrambled once the
  // setup edge has passed, since the completer must only use what it latched.
  task automatic setup_phase(input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] wcfg);
    @(posedge PCLK); #1;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = wr;
    bus.PADDR   = addr;
    bus.PWDATA  = wdata;
    WAIT_CFG    = wcfg;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    bus.PWRITE  = ~wr;
    bus.PADDR   = ~addr;
    bus.PWDATA  = ~wdata;
    WAIT_CFG    = ~wcfg;
  endtask

  task automatic finish_xfer(input string name, output logic [31:0] rdata,
                             output logic err, output int cycles);
    logic got;
    got    = 1'b0;
    cycles = 0;
    rdata  = 32'h0;
    err    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge PCLK);
      cycles++;
      if (bus.PREADY === 1'b1) begin
        rdata = bus.PRDATA;
        err   = bus.PSLVERR;
        got   = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_total++;
      $display("FAIL %s timeout: PREADY never rose within 40 cycles", name);
    end
    @(posedge PCLK); #1;
    bus_idle();
  endtask

  task automatic xfer(input string name, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wcfg,
                      output logic [31:0] rdata, output logic err, output int cycles);
    setup_phase(wr, addr, wdata, wcfg);
    finish_xfer(name, rdata, err, cycles);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          cyc;

    vecs[0]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'd0, 32'h0000_0000, 1'b0, 1};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'd0, 32'hDEAD_BEEF, 1'b0, 1};
    vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0,         4'd3, 32'h0000_0000, 1'b0, 4};
    vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,         4'd0, 32'h0000_0000, 1'b1, 1};
    vecs[4]  = '{1'b1, 32'h0000_0006, 32'hCAFE_F00D, 4'd1, 32'h0000_0000, 1'b1, 2};
    vecs[5]  = '{1'b0, 32'h0000_0004, 32'h0,         4'd0, 32'hDEAD_BEEF, 1'b0, 1};
    vecs[6]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 4'd0, 32'h0000_0000, 1'b1, 1};
    vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'd2, 32'h0000_0000, 1'b0, 3};
    vecs[8]  = '{1'b1, 32'h0000_003C, 32'hA5A5_5A5A, 4'd2, 32'h0000_0000, 1'b0, 3};
    vecs[9]  = '{1'b0, 32'hFFFF_FC3C, 32'h0,         4'd0, 32'hA5A5_5A5A, 1'b0, 1};
    vecs[10] = '{1'b0, 32'h0000_0400, 32'h0,         4'd0, 32'h0000_0000, 1'b0, 1};

    bus_idle();
    WAIT_CFG = 4'd0;
    PRESETN  = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset PREADY",    32'(bus.PREADY),  32'h0);
    chk("reset PSLVERR",   32'(bus.PSLVERR), 32'h0);
    chk("reset PRDATA",    bus.PRDATA,       32'h0);
    chk("reset XFER_CNT",  32'(XFER_CNT),    32'h0);
    chk("reset ERR_CNT",   32'(ERR_CNT),     32'h0);
    chk("reset PROTO_ERR", 32'(PROTO_ERR),   32'h0);
    PRESETN = 1'b1;

    for (int i = 0; i < 11; i++) begin
      xfer($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wcfg,
           rd, er, cyc);
      chk($sformatf("v%0d PRDATA", i),  rd,       vecs[i].exp_rdata);
      chk($sformatf("v%0d PSLVERR", i), 32'(er),  32'(vecs[i].exp_err));
      chk($sformatf("v%0d cycles", i),  32'(cyc), 32'(vecs[i].exp_cycles));
    end
    chk("table XFER_CNT",  32'(XFER_CNT),  32'd11);
    chk("table ERR_CNT",   32'(ERR_CNT),   32'd3);
    chk("table PROTO_ERR", 32'(PROTO_ERR), 32'd0);

    // Abort: PSEL dropped in the second wait cycle of a 3-wait write.
    setup_phase(1'b1, 32'h0000_0008, 32'h1111_2222, 4'd3);
    @(posedge PCLK); #1;
    bus_idle();
    @(posedge PCLK); #1;
    chk("abort PROTO_ERR", 32'(PROTO_ERR),  32'd1);
    chk("abort XFER_CNT",  32'(XFER_CNT),   32'd11);
    chk("abort PREADY",    32'(bus.PREADY), 32'd0);
    xfer("post-abort", 1'b0, 32'h0000_0008, 32'h0, 4'd0, rd, er, cyc);
    chk("post-abort PRDATA",   rd,            32'h0);
    chk("post-abort PSLVERR",  32'(er),       32'd0);
    chk("post-abort XFER_CNT", 32'(XFER_CNT), 32'd12);

    // Reset asserted in the middle of a 5-wait write.
    setup_phase(1'b1, 32'h0000_0010, 32'h0000_0077, 4'd5);
    @(posedge PCLK); #1;
    PRESETN = 1'b0;
    #1;
    chk("midrst PREADY",    32'(bus.PREADY),  32'd0);
    chk("midrst PSLVERR",   32'(bus.PSLVERR), 32'd0);
    chk("midrst XFER_CNT",  32'(XFER_CNT),    32'd0);
    chk("midrst ERR_CNT",   32'(ERR_CNT),     32'd0);
    chk("midrst PROTO_ERR", 32'(PROTO_ERR),   32'd0);
    bus_idle();
    @(posedge PCLK); #1;
    PRESETN = 1'b1;
    xfer("cleared 0x04", 1'b0, 32'h0000_0004, 32'h0, 4'd0, rd, er, cyc);
    chk("cleared 0x04 PRDATA", rd, 32'h0);
    xfer("cleared 0x10", 1'b0, 32'h0000_0010, 32'h0, 4'd0, rd, er, cyc);
    chk("cleared 0x10 PRDATA", rd, 32'h0);

    // Access phase with no preceding setup.
    @(posedge PCLK); #1;
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b1;
    bus.PADDR   = 32'h0000_0004;
    @(posedge PCLK); #1;
    chk("nosetup PROTO_ERR", 32'(PROTO_ERR),  32'd1);
    chk("nosetup PREADY",    32'(bus.PREADY), 32'd0);
    bus_idle();
    @(posedge PCLK); #1;
    chk("nosetup XFER_CNT",  32'(XFER_CNT),   32'd2);

    // ERR_CNT saturation over 256 out-of-range reads.
    for (int i = 0; i < 254; i++) xfer("sat", 1'b0, 32'h0000_0040, 32'h0, 4'd0, rd, er, cyc);
    chk("sat ERR_CNT 254", 32'(ERR_CNT), 32'h0000_00FE);
    xfer("sat", 1'b0, 32'h0000_0040, 32'h0, 4'd0, rd, er, cyc);
    chk("sat ERR_CNT 255", 32'(ERR_CNT), 32'h0000_00FF);
    xfer("sat", 1'b0, 32'h0000_0040, 32'h0, 4'd0, rd, er, cyc);
    chk("sat ERR_CNT 256", 32'(ERR_CNT), 32'h0000_00FF);
    chk("sat PSLVERR",     32'(er),       32'd1);
    chk("sat XFER_CNT",    32'(XFER_CNT), 32'd258);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
